// File: rtl/clkdiv_pkg.sv
// Shared constants for the multi-channel clock-enable generator: default widths,
// hardware and simulation divisor sets, and the reset-divisor packing helper.
package clkdiv_pkg;

  localparam int unsigned NCH_DEF = 4;
  localparam int unsigned CW_DEF  = 27;

  // Hardware divisors for a 100 MHz clk
  localparam logic [CW_DEF-1:0] DIV_1HZ  = CW_DEF'(100_000_000);
  localparam logic [CW_DEF-1:0] DIV_2HZ  = CW_DEF'(50_000_000);
  localparam logic [CW_DEF-1:0] DIV_SCAN = CW_DEF'(262_144);
  localparam logic [CW_DEF-1:0] DIV_ADJ  = CW_DEF'(20_000_000);

  // Shortened set so simulations see several periods quickly
  localparam logic [CW_DEF-1:0] DIV_1HZ_SIM  = CW_DEF'(10_000);
  localparam logic [CW_DEF-1:0] DIV_2HZ_SIM  = CW_DEF'(5_000);
  localparam logic [CW_DEF-1:0] DIV_SCAN_SIM = CW_DEF'(26);
  localparam logic [CW_DEF-1:0] DIV_ADJ_SIM  = CW_DEF'(2_000);

  // Packs four divisors with ch0 in the LSBs
  function automatic logic [NCH_DEF*CW_DEF-1:0] pack_div4(
    input logic [CW_DEF-1:0] d0,
    input logic [CW_DEF-1:0] d1,
    input logic [CW_DEF-1:0] d2,
    input logic [CW_DEF-1:0] d3
  );
    return {d3, d2, d1, d0};
  endfunction

  localparam logic [NCH_DEF*CW_DEF-1:0] DIV_INIT_HW =
    pack_div4(DIV_1HZ, DIV_2HZ, DIV_SCAN, DIV_ADJ);
  localparam logic [NCH_DEF*CW_DEF-1:0] DIV_INIT_SIM =
    pack_div4(DIV_1HZ_SIM, DIV_2HZ_SIM, DIV_SCAN_SIM, DIV_ADJ_SIM);

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: period counter, loadable divisor, registered tick and
// square-wave output.
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int unsigned     CW      = CW_DEF,
  parameter logic [CW-1:0]   DIV_RST = CW'(1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          active,
  input  logic          clr,
  input  logic          ld,
  input  logic [CW-1:0] ld_div,
  output logic          tick,
  output logic          sq
);

  logic [CW-1:0] cnt;
  logic [CW-1:0] div;
  logic [CW-1:0] eff_div_c;
  logic          term_c;

  // A zero divisor behaves like 1 so the channel never stalls
  always_comb begin
    eff_div_c = (div == '0) ? CW'(1) : div;
    term_c    = (cnt >= (eff_div_c - CW'(1)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      div  <= DIV_RST;
      tick <= 1'b0;
      sq   <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (ld) begin
        div <= ld_div;
      end
      // clr and load both restart the period; only clr realigns sq
      if (clr) begin
        cnt <= '0;
        sq  <= 1'b0;
      end else if (ld) begin
        cnt <= '0;
      end else if (active) begin
        if (term_c) begin
          cnt  <= '0;
          tick <= 1'b1;
          sq   <= ~sq;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/clkdiv_multi.sv
// N-channel clock-enable generator with per-channel run-time divisors; decodes the
// shared divisor-load port and flags out-of-range selects.
module clkdiv_multi
  import clkdiv_pkg::*;
#(
  parameter int unsigned         NCH      = NCH_DEF,
  parameter int unsigned         CW       = CW_DEF,
  parameter logic [NCH*CW-1:0]   DIV_INIT = DIV_INIT_HW,
  parameter int unsigned         SELW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            clr,
  input  logic [NCH-1:0]  ch_en,
  input  logic            ld,
  input  logic [SELW-1:0] ld_sel,
  input  logic [CW-1:0]   ld_div,
  output logic [NCH-1:0]  tick,
  output logic [NCH-1:0]  sq,
  output logic            ld_err
);

  logic ld_hit_c;

  assign ld_hit_c = ld && (32'(ld_sel) < 32'(NCH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_err <= 1'b0;
    end else begin
      ld_err <= ld && !ld_hit_c;
    end
  end

  for (genvar i = 0; i < int'(NCH); i++) begin : g_chan
    clkdiv_chan #(
      .CW      (CW),
      .DIV_RST (DIV_INIT[i*CW +: CW])
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .active (en && ch_en[i]),
      .clr    (clr),
      .ld     (ld_hit_c && (ld_sel == SELW'(i))),
      .ld_div (ld_div),
      .tick   (tick[i]),
      .sq     (sq[i])
    );
  end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Directed bench for clkdiv_multi: a 4-channel instance for timing, pause, load and
// clear behaviour, and a 3-channel instance for out-of-range load selects.
module tb_clkdiv_multi;

  localparam int unsigned CW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            en, clr, ld, ld_err;
  logic [3:0]      ch_en, tick, sq;
  logic [1:0]      ld_sel;
  logic [CW-1:0]   ld_div;

  logic            b_en, b_clr, b_ld, b_ld_err;
  logic [2:0]      b_ch_en, b_tick, b_sq;
  logic [1:0]      b_ld_sel;
  logic [CW-1:0]   b_ld_div;

  clkdiv_multi #(
    .NCH(4), .CW(CW), .DIV_INIT({8'd1, 8'd2, 8'd3, 8'd4})
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .ch_en(ch_en), .ld(ld),
    .ld_sel(ld_sel), .ld_div(ld_div), .tick(tick), .sq(sq), .ld_err(ld_err)
  );

  clkdiv_multi #(
    .NCH(3), .CW(CW), .DIV_INIT({8'd7, 8'd6, 8'd5})
  ) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en(b_en), .clr(b_clr), .ch_en(b_ch_en), .ld(b_ld),
    .ld_sel(b_ld_sel), .ld_div(b_ld_div), .tick(b_tick), .sq(b_sq), .ld_err(b_ld_err)
  );

  typedef struct {
    logic       en;
    logic [3:0] tick;
    logic [3:0] sq;
  } vec_t;

  vec_t tbl[14];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [2:0] b_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // divs ch3..ch0 = 1,2,3,4; bits listed ch3..ch0
    tbl[0]  = '{1'b1, 4'b1000, 4'b1000};
    tbl[1]  = '{1'b1, 4'b1100, 4'b0100};
    tbl[2]  = '{1'b1, 4'b1010, 4'b1110};
    tbl[3]  = '{1'b1, 4'b1101, 4'b0011};
    tbl[4]  = '{1'b1, 4'b1000, 4'b1011};
    tbl[5]  = '{1'b1, 4'b1110, 4'b0101};
    tbl[6]  = '{1'b1, 4'b1000, 4'b1101};
    tbl[7]  = '{1'b1, 4'b1101, 4'b0000};
    tbl[8]  = '{1'b1, 4'b1010, 4'b1010};
    tbl[9]  = '{1'b1, 4'b1100, 4'b0110};
    tbl[10] = '{1'b1, 4'b1000, 4'b1110};
    tbl[11] = '{1'b1, 4'b1111, 4'b0001};
    tbl[12] = '{1'b0, 4'b0000, 4'b0001};
    tbl[13] = '{1'b1, 4'b1000, 4'b1001};

    en = 1'b0; clr = 1'b0; ld = 1'b0; ch_en = '0; ld_sel = '0; ld_div = '0;
    b_en = 1'b0; b_clr = 1'b0; b_ld = 1'b0; b_ch_en = '0; b_ld_sel = '0; b_ld_div = '0;

    #12;
    chk("rst_tick", 32'(tick), 32'(0));
    chk("rst_sq", 32'(sq), 32'(0));
    chk("rst_ld_err", 32'(ld_err), 32'(0));
    chk("rst_b_ld_err", 32'(b_ld_err), 32'(0));

    rst_n = 1'b1;
    en = 1'b1; ch_en = 4'hf; b_en = 1'b1; b_ch_en = 3'b111;
    for (int i = 0; i < 14; i++) begin
      en = tbl[i].en;
      step();
      chk($sformatf("lat_tick[%0d]", i), 32'(tick), 32'(tbl[i].tick));
      chk($sformatf("lat_sq[%0d]", i), 32'(sq), 32'(tbl[i].sq));
    end
    en = 1'b1;

    // Pause: ch0 div 5, two active edges, 7 paused, tick on 3rd edge after resume
    ld = 1'b1; ld_sel = 2'd0; ld_div = 8'd5;
    step();
    ld = 1'b0;
    chk("pause_ld_tick0", 32'(tick[0]), 32'(0));
    chk("pause_ld_sq0", 32'(sq[0]), 32'(1));
    chk("pause_ld_err", 32'(ld_err), 32'(0));
    for (int k = 0; k < 2; k++) begin
      step();
      chk("pause_pre_tick0", 32'(tick[0]), 32'(0));
    end
    ch_en[0] = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step();
      chk("pause_hold_tick0", 32'(tick[0]), 32'(0));
      chk("pause_hold_sq0", 32'(sq[0]), 32'(1));
    end
    ch_en[0] = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("resume_tick0[%0d]", k), 32'(tick[0]), 32'(k == 3));
      chk($sformatf("resume_sq0[%0d]", k), 32'(sq[0]), 32'(k != 3));
    end

    // Load ch2 div 6 mid-count, then div 0
    ld = 1'b1; ld_sel = 2'd2; ld_div = 8'd6;
    step();
    ld = 1'b0;
    chk("ld6_tick2", 32'(tick[2]), 32'(0));
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("ld6_tick2[%0d]", k), 32'(tick[2]), 32'(k == 6));
    end
    ld = 1'b1; ld_sel = 2'd2; ld_div = 8'd0;
    step();
    ld = 1'b0;
    chk("ld0_tick2", 32'(tick[2]), 32'(0));
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("ld0_tick2[%0d]", k), 32'(tick[2]), 32'(1));
    end

    // Load on a channel sitting at terminal count suppresses that edge's tick
    ld = 1'b1; ld_sel = 2'd3; ld_div = 8'd1;
    step();
    ld = 1'b0;
    chk("ldterm_tick3", 32'(tick[3]), 32'(0));
    step();
    chk("ldterm_next_tick3", 32'(tick[3]), 32'(1));

    // clr and ld on the same edge
    clr = 1'b1; ld = 1'b1; ld_sel = 2'd1; ld_div = 8'd9;
    step();
    clr = 1'b0; ld = 1'b0;
    chk("clrld_tick", 32'(tick), 32'(0));
    chk("clrld_sq", 32'(sq), 32'(0));
    for (int k = 1; k <= 9; k++) begin
      step();
      chk($sformatf("clrld_tick1[%0d]", k), 32'(tick[1]), 32'(k == 9));
    end
    chk("clrld_sq1", 32'(sq[1]), 32'(1));

    // Out-of-range select on the 3-channel instance
    b_ld = 1'b1; b_ld_sel = 2'd3; b_ld_div = 8'd0;
    step();
    b_ld = 1'b0;
    chk("badsel_ld_err", 32'(b_ld_err), 32'(1));
    b_clr = 1'b1;
    step();
    b_clr = 1'b0;
    chk("badsel_ld_err_drop", 32'(b_ld_err), 32'(0));
    chk("badsel_clr_tick", 32'(b_tick), 32'(0));
    for (int k = 1; k <= 7; k++) begin
      step();
      b_exp = (k == 5) ? 3'b001 : (k == 6) ? 3'b010 : (k == 7) ? 3'b100 : 3'b000;
      chk($sformatf("badsel_tick[%0d]", k), 32'(b_tick), 32'(b_exp));
    end

    // Async reset between edges, then reset divisors must be back
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_tick", 32'(tick), 32'(0));
    chk("arst_sq", 32'(sq), 32'(0));
    chk("arst_b_tick", 32'(b_tick), 32'(0));
    chk("arst_b_sq", 32'(b_sq), 32'(0));
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("arst_relat_tick[%0d]", i), 32'(tick), 32'(tbl[i].tick));
      chk($sformatf("arst_relat_sq[%0d]", i), 32'(sq), 32'(tbl[i].sq));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
